// File: rtl/data_mem_ctrl.sv
// Initiator-side controller for the single-port data memory.
// Accepts read/write/clear-all requests over a valid/ready channel, drives the
// memory pins from registers only, and returns the result on a valid/ready
// response channel. One transaction is in flight at a time.
//
// Memory pins are registered, so they lag the state by one edge. The first
// edge in READ/WRITE/CLEAR raises the strobe. The edge that sees the strobe
// already high completes the access. This gives read/write responses two
// edges after the request handshake, and clear responses SIZE+1 edges after it.
module data_mem_ctrl #(
  parameter int unsigned WORDSIZE = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned SIZE     = 32
) (
  input  logic                clk,
  input  logic                reset,
  // request channel
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_cmd,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [WORDSIZE-1:0] req_wdata,
  // response channel
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [WORDSIZE-1:0] resp_rdata,
  output logic                resp_err,
  // memory pins
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORDSIZE-1:0] mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [WORDSIZE-1:0] mem_rdata
);

  localparam logic [1:0] CmdRead  = 2'b00;
  localparam logic [1:0] CmdWrite = 2'b01;
  localparam logic [1:0] CmdClear = 2'b10;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(SIZE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StClear,
    StResp
  } state_e;

  state_e              state;
  logic [1:0]          cmd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORDSIZE-1:0] wdata_q;
  logic [ADDR_W-1:0]   clr_cnt;

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      clr_cnt    <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (req_valid && req_ready) begin
            cmd_q     <= req_cmd;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            case (req_cmd)
              CmdRead:  state <= StRead;
              CmdWrite: state <= StWrite;
              CmdClear: state <= StClear;
              // Illegal command: no memory access. RESP raises valid and err.
              default:  state <= StResp;
            endcase
          end
        end

        StRead: begin
          if (!mem_re) begin
            mem_re   <= 1'b1;
            mem_addr <= addr_q;
          end else begin
            // Memory read is combinational while mem_re is high.
            mem_re     <= 1'b0;
            mem_addr   <= '0;
            resp_rdata <= mem_rdata;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= StResp;
          end
        end

        StWrite: begin
          if (!mem_we) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr_q;
            mem_wdata <= wdata_q;
          end else begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= StResp;
          end
        end

        StClear: begin
          if (!mem_we) begin
            mem_we    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            clr_cnt   <= '0;
          end else if (clr_cnt == LastAddr) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            clr_cnt    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= StResp;
          end else begin
            // clr_cnt always equals the address currently being written.
            clr_cnt  <= clr_cnt + ADDR_W'(1);
            mem_addr <= clr_cnt + ADDR_W'(1);
          end
        end

        StResp: begin
          if (!resp_valid) begin
            // Only reached from an illegal command.
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_err   <= (cmd_q == 2'b11);
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= StIdle;
          end
        end

        default: begin
          state     <= StIdle;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
